// File: rtl/dds_sine_core.sv
// Phase-accumulator DDS: FTW accumulation, quarter-wave sine ROM, fixed 3-cycle output pipeline.
// Optional LFSR phase dithering before truncation is enabled by defining DDS_PHASE_DITHER_EN.
module dds_sine_core #(
  parameter int ACC_W  = 32,
  parameter int LUT_AW = 8,
  parameter int OUT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ACC_W-1:0]  ftw_data,
  input  logic              ftw_valid,
  output logic              ftw_ready,
  input  logic [LUT_AW+1:0] phase_off,
  output logic [OUT_W-1:0]  sample,
  output logic              sample_valid,
  output logic              cycle_start
);
  localparam int  PH_W  = LUT_AW + 2;
  localparam int  ROM_W = OUT_W - 1;
  localparam int  ROM_N = 1 << LUT_AW;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = real'((1 << ROM_W) - 1);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] ftw_active_reg;
  logic [ACC_W-1:0] ftw_pending_reg;
  logic             pending_reg;
  logic             wrap_reg;
  logic [ACC_W:0]   acc_sum;
  logic             wrap;
  logic             apply;

  assign acc_sum = {1'b0, acc_reg} + {1'b0, ftw_active_reg};
  assign wrap    = enable & acc_sum[ACC_W];
  // A new word only takes effect where it cannot cut an output period short.
  assign apply   = pending_reg & (wrap | ~enable | (ftw_active_reg == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg         <= '0;
      ftw_active_reg  <= '0;
      ftw_pending_reg <= '0;
      pending_reg     <= 1'b0;
      ftw_ready       <= 1'b1;
      wrap_reg        <= 1'b0;
    end else begin
      if (enable)
        acc_reg <= acc_sum[ACC_W-1:0];
      wrap_reg <= wrap;
      if (apply) begin
        ftw_active_reg <= ftw_pending_reg;
        pending_reg    <= 1'b0;
        ftw_ready      <= 1'b1;
      end else if (ftw_valid && ftw_ready) begin
        ftw_pending_reg <= ftw_data;
        pending_reg     <= 1'b1;
        ftw_ready       <= 1'b0;
      end
    end
  end

  logic round_up;
`ifdef DDS_PHASE_DITHER_EN
  localparam int D = ACC_W - PH_W;
  logic [31:0] lfsr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr_reg <= 32'h1;
    else if (enable)
      lfsr_reg <= {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? 32'h8020_0003 : 32'h0);
  end

  // Carry out of acc_low + lfsr_low, expressed without a wide adder.
  assign round_up = acc_reg[D-1:0] > ~lfsr_reg[D-1:0];
`else
  assign round_up = 1'b0;
`endif

  logic [PH_W-1:0]   phase;
  logic [LUT_AW-1:0] idx;

  assign phase = acc_reg[ACC_W-1 -: PH_W] + phase_off + PH_W'(round_up);
  assign idx   = phase[PH_W-2] ? ~phase[LUT_AW-1:0] : phase[LUT_AW-1:0];

  // Half-LSB offset makes the quarter wave mirror exactly across quadrants.
  logic [ROM_W-1:0] rom [ROM_N];
  for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
    localparam real ANG = PI / 2.0 * (real'(gi) + 0.5) / real'(ROM_N);
    assign rom[gi] = ROM_W'($rtoi(AMP * $sin(ANG) + 0.5));
  end

  logic [LUT_AW-1:0] s1_idx_reg;
  logic              s1_neg_reg, s1_valid_reg, s1_wrap_reg;
  logic [ROM_W-1:0]  s2_mag_reg;
  logic              s2_neg_reg, s2_valid_reg, s2_wrap_reg;
  logic [OUT_W-1:0]  mag_ext;

  assign mag_ext = {1'b0, s2_mag_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_idx_reg   <= '0;
      s1_neg_reg   <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_wrap_reg  <= 1'b0;
      s2_mag_reg   <= '0;
      s2_neg_reg   <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_wrap_reg  <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      cycle_start  <= 1'b0;
    end else begin
      s1_idx_reg   <= idx;
      s1_neg_reg   <= phase[PH_W-1];
      s1_valid_reg <= enable;
      s1_wrap_reg  <= wrap_reg;
      s2_mag_reg   <= rom[s1_idx_reg];
      s2_neg_reg   <= s1_neg_reg;
      s2_valid_reg <= s1_valid_reg;
      s2_wrap_reg  <= s1_wrap_reg;
      sample_valid <= s2_valid_reg;
      cycle_start  <= s2_wrap_reg;
      if (s2_valid_reg)
        sample <= s2_neg_reg ? (OUT_W'(0) - mag_ext) : mag_ext;
    end
  end
endmodule

// File: tb/tb_dds_sine_core.sv
// Self-checking bench for dds_sine_core: cycle model feeding a sample scoreboard,
// a table of steady-state tuning vectors, and hand-built handshake/enable/reset sequences.
module tb_dds_sine_core;
  localparam real PI = 3.14159265358979323846;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       ftw_valid = 1'b0;
  logic [31:0] ftw_data = '0;
  logic [9:0] phase_off = '0;
  logic       ftw_ready;
  logic [9:0] sample;
  logic       sample_valid;
  logic       cycle_start;

  dds_sine_core dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ftw_data(ftw_data), .ftw_valid(ftw_valid), .ftw_ready(ftw_ready),
    .phase_off(phase_off), .sample(sample), .sample_valid(sample_valid),
    .cycle_start(cycle_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   s;
    logic cs;
  } exp_t;

  typedef struct {
    logic [31:0] ftw;
    logic [9:0]  off;
    int          cycles;
    int          peak;
    int          trough;
    int          starts;
  } vec_t;

  exp_t sb[$];
  int   cs_ticks[$];
  vec_t vecs[6];

  logic [31:0] acc_m, ftw_m, pend_v;
  logic        pend_m, rdy_m, wrapf_m;
  logic [2:0]  en_sh;
`ifdef DDS_PHASE_DITHER_EN
  logic [31:0] lfsr_m;
`endif
  int n_cmp = 0, n_bad = 0;
  int tick_no, cs_count, last_s, s_max, s_min;

  function automatic int ref_sample(logic [9:0] p);
    real a;
    a = 511.0 * $sin(2.0 * PI * (real'(p) + 0.5) / 1024.0);
    if (a >= 0.0) return $rtoi(a + 0.5);
    return -$rtoi(-a + 0.5);
  endfunction

  function automatic int cs_at(int i);
    if (i < cs_ticks.size()) return cs_ticks[i];
    return -1;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @tick %0d: got %0d, required %0d", name, tick_no, act, exp);
    end
  endtask

  task automatic clear_stats();
    tick_no = 0; cs_count = 0; cs_ticks.delete();
    s_max = -1024; s_min = 1024;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; ftw_valid = 1'b0; ftw_data = '0;
    #1;
    check("rst_sample", int'($signed(sample)), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    check("rst_cycle_start", int'(cycle_start), 0);
    check("rst_ftw_ready", int'(ftw_ready), 1);
    acc_m = '0; ftw_m = '0; pend_v = '0; pend_m = 1'b0; rdy_m = 1'b1;
    wrapf_m = 1'b0; en_sh = '0; last_s = 0; sb.delete();
`ifdef DDS_PHASE_DITHER_EN
    lfsr_m = 32'h1;
`endif
    clear_stats();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic tick();
    exp_t        e;
    logic [32:0] sum;
    logic        wrap, apply, capture, dc;
    logic [9:0]  p;
    int          s_now;
    sum  = {1'b0, acc_m} + {1'b0, ftw_m};
    wrap = enable & sum[32];
    if (enable) begin
      dc = 1'b0;
`ifdef DDS_PHASE_DITHER_EN
      dc = ({1'b0, acc_m[21:0]} + {1'b0, lfsr_m[21:0]}) >= 23'h40_0000;
`endif
      p = acc_m[31:22] + phase_off + {9'b0, dc};
      e.s = ref_sample(p);
      e.cs = wrapf_m;
      sb.push_back(e);
    end
    apply   = pend_m & (wrap | ~enable | (ftw_m == 32'd0));
    capture = ftw_valid & rdy_m;
    if (enable) begin
      acc_m = sum[31:0];
`ifdef DDS_PHASE_DITHER_EN
      lfsr_m = {1'b0, lfsr_m[31:1]} ^ (lfsr_m[0] ? 32'h8020_0003 : 32'h0);
`endif
    end
    wrapf_m = wrap;
    if (apply) begin ftw_m = pend_v; pend_m = 1'b0; rdy_m = 1'b1; end
    if (capture) begin pend_v = ftw_data; pend_m = 1'b1; rdy_m = 1'b0; end
    en_sh = {en_sh[1:0], enable};

    @(posedge clk); #1;
    tick_no++;
    s_now = int'($signed(sample));
    check("ftw_ready", int'(ftw_ready), int'(rdy_m));
    check("sample_valid", int'(sample_valid), int'(en_sh[2]));
    if (cycle_start) begin
      cs_count++;
      cs_ticks.push_back(tick_no);
    end
    if (sample_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow @tick %0d: got sample_valid with empty scoreboard, required queued entry", tick_no);
      end else begin
        e = sb.pop_front();
        check("sample", s_now, e.s);
        check("cycle_start", int'(cycle_start), int'(e.cs));
        last_s = e.s;
        if (s_now > s_max) s_max = s_now;
        if (s_now < s_min) s_min = s_now;
      end
    end else begin
      check("sample_hold", s_now, last_s);
    end
  endtask

  task automatic load(logic [31:0] w);
    enable = 1'b0; ftw_valid = 1'b1; ftw_data = w;
    tick();
    ftw_valid = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{32'h0040_0000, 10'd0,   3000, 511, -511, 2};
    vecs[1] = '{32'h0080_0000, 10'd0,   3000, 511, -511, 5};
    vecs[2] = '{32'h0020_0000, 10'd0,   2000, 511, -511, 0};
    vecs[3] = '{32'h0000_0000, 10'd0,    100,   2,    2, 0};
    vecs[4] = '{32'h0040_0000, 10'd256, 3000, 511, -511, 2};
    vecs[5] = '{32'h8000_0000, 10'd0,    200,   2,   -2, 100};

    #3;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      phase_off = vecs[v].off;
      load(vecs[v].ftw);
      clear_stats();
      enable = 1'b1;
      repeat (vecs[v].cycles) tick();
      enable = 1'b0;
      repeat (3) tick();
      check("peak", s_max, vecs[v].peak);
      check("trough", s_min, vecs[v].trough);
      check("cycle_starts", cs_count, vecs[v].starts);
      $display("vec %0d ftw=%h off=%0d peak=%0d trough=%0d starts=%0d",
               v, vecs[v].ftw, vecs[v].off, s_max, s_min, cs_count);
    end
    phase_off = '0;

    // Mid-period retune: old period completes, then 512-cycle periods.
    do_reset();
    load(32'h0040_0000);
    clear_stats();
    enable = 1'b1;
    repeat (300) tick();
    ftw_valid = 1'b1; ftw_data = 32'h0080_0000;
    tick();
    ftw_valid = 1'b0;
    check("retune_ready_low", int'(ftw_ready), 0);
    repeat (2100 - 301) tick();
    check("retune_cs0", cs_at(0), 1027);
    check("retune_cs1", cs_at(1), 1539);
    check("retune_cs2", cs_at(2), 2051);
    $display("seq retune cs=%0d,%0d,%0d", cs_at(0), cs_at(1), cs_at(2));

    // Word captured on the wrap edge waits for the following wrap.
    do_reset();
    load(32'h0040_0000);
    clear_stats();
    enable = 1'b1;
    repeat (1023) tick();
    ftw_valid = 1'b1; ftw_data = 32'h0080_0000;
    tick();
    ftw_valid = 1'b0;
    repeat (2700 - 1024) tick();
    check("wrapcap_cs0", cs_at(0), 1027);
    check("wrapcap_cs1", cs_at(1), 2051);
    check("wrapcap_cs2", cs_at(2), 2563);
    $display("seq wrap-capture cs=%0d,%0d,%0d", cs_at(0), cs_at(1), cs_at(2));

    // Disable with a pending word: applied at once, output holds, resumes from held phase.
    do_reset();
    load(32'h0040_0000);
    clear_stats();
    enable = 1'b1;
    repeat (500) tick();
    ftw_valid = 1'b1; ftw_data = 32'h0080_0000;
    tick();
    ftw_valid = 1'b0;
    enable = 1'b0;
    tick();
    check("disable_apply_ready", int'(ftw_ready), 1);
    repeat (8) tick();
    check("disable_valid_low", int'(sample_valid), 0);
    check("disable_hold", int'($signed(sample)), last_s);
    enable = 1'b1;
    repeat (600) tick();
    check("resume_cs0", cs_at(0), 775);
    check("resume_cs_count", cs_count, 1);
    $display("seq disable/resume cs=%0d count=%0d", cs_at(0), cs_count);

    // Reset with a word pending: word is lost, accumulator stays at zero.
    do_reset();
    load(32'h0040_0000);
    enable = 1'b1;
    repeat (200) tick();
    ftw_valid = 1'b1; ftw_data = 32'h0080_0000;
    tick();
    ftw_valid = 1'b0;
    repeat (5) tick();
    #2;
    do_reset();
    enable = 1'b1;
    repeat (50) tick();
    check("ftw_lost_sample", int'($signed(sample)), 2);
    check("ftw_lost_cs", cs_count, 0);
    $display("seq reset-pending sample=%0d", int'($signed(sample)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
